// File: rtl/passageway_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : passageway_pkg                                          |
// | Purpose  : Shared types, constants and helpers for the passageway  |
// |            agent and its step watchdog.                            |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
package passageway_pkg;

  // Agent movement mode; DONE is terminal until reset.
  typedef enum logic [1:0] {
    CLOSED   = 2'd0,
    OPEN     = 2'd1,
    DOORSTEP = 2'd2,
    DONE     = 2'd3
  } mode_t;

  localparam int NZONES_DEFAULT = 5;
  // Zone index width; wide enough for every zone of the default corridor.
  localparam int ZONE_W = 3;

  // One-hot zone decode; an out-of-range index decodes to all zeros.
  function automatic logic [NZONES_DEFAULT-1:0] zone_onehot(input logic [ZONE_W-1:0] idx);
    logic [NZONES_DEFAULT-1:0] oh;
    oh = '0;
    for (int i = 0; i < NZONES_DEFAULT; i++) begin
      if (idx == ZONE_W'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/passageway_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : passageway_if                                           |
// | Purpose  : Stimulus/observation bundle between the tester and the  |
// |            passageway agent.                                       |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
interface passageway_if #(
  parameter int STEP_W = 7
);
  // Tester stimulus
  logic              iup;
  logic              iright;
  logic              fault_inject;
  // Agent observations
  logic              controllable_zone0;
  logic              controllable_zone1;
  logic              controllable_zone2;
  logic              controllable_zone3;
  logic              controllable_zone4;
  logic              controllable_open;
  logic              controllable_doorstep;
  logic              controllable_fault;
  logic              done;
  logic [STEP_W-1:0] steps;

  // Tester side: drives stimulus, reads observations.
  modport master (
    output iup, iright, fault_inject,
    input  controllable_zone0, controllable_zone1, controllable_zone2,
    input  controllable_zone3, controllable_zone4,
    input  controllable_open, controllable_doorstep, controllable_fault,
    input  done, steps
  );

  // Agent side: reads stimulus, drives observations.
  modport slave (
    input  iup, iright, fault_inject,
    output controllable_zone0, controllable_zone1, controllable_zone2,
    output controllable_zone3, controllable_zone4,
    output controllable_open, controllable_doorstep, controllable_fault,
    output done, steps
  );
endinterface
`default_nettype wire

// File: rtl/passageway_step_watchdog.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : passageway_step_watchdog                                |
// | Purpose  : Saturating move counter that flags the edge on which    |
// |            the count lands on the step budget.                     |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module passageway_step_watchdog #(
  parameter int MAX_STEPS = 64,
  parameter int STEP_W    = 7
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              en_i,
  output logic      [STEP_W-1:0] count_o,
  output logic                   limit_o
);

  localparam logic [STEP_W-1:0] LIMIT = STEP_W'(MAX_STEPS);

  logic [STEP_W-1:0] count_q;
  logic [STEP_W-1:0] count_d;

  // Next count: step when enabled, hold once all ones.
  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != '1)) count_d = count_q + STEP_W'(1);
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;
  // Only a counting edge can reach the budget, so a frozen count never re-fires.
  assign limit_o = en_i && (count_d == LIMIT);

endmodule
`default_nettype wire

// File: rtl/passageway_agent.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : passageway_agent                                        |
// | Purpose  : Reference agent crossing a corridor of zones, one move  |
// |            per cycle, with sticky fault and step watchdog.         |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module passageway_agent
  import passageway_pkg::*;
#(
  parameter int NZONES    = NZONES_DEFAULT,
  parameter int MAX_STEPS = 64,
  parameter int STEP_W    = 7
) (
  input wire logic    clk,
  input wire logic    rst,
  passageway_if.slave bus
);

  localparam logic [ZONE_W-1:0] LAST_ZONE = ZONE_W'(NZONES - 1);

  mode_t                   mode_q;
  mode_t                   mode_d;
  logic [ZONE_W-1:0]       zone_q;
  logic [ZONE_W-1:0]       zone_d;
  logic [ZONE_W-1:0]       zone_inc;
  logic                    fault_q;
  logic                    fault_d;
  logic                    wd_en;
  logic                    wd_limit;
  logic [STEP_W-1:0]       wd_count;
  logic [NZONES_DEFAULT-1:0] zone_oh;

  // Moves are counted only while the agent is still live.
  assign wd_en    = (mode_q != DONE) && !fault_q;
  assign zone_inc = zone_q + ZONE_W'(1);

  passageway_step_watchdog #(
    .MAX_STEPS (MAX_STEPS),
    .STEP_W    (STEP_W)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .en_i    (wd_en),
    .count_o (wd_count),
    .limit_o (wd_limit)
  );

  // Mode/zone next state and sticky fault; a fault freezes movement.
  always_comb begin
    mode_d = mode_q;
    zone_d = zone_q;
    if (!fault_q) begin
      case (mode_q)
        CLOSED: begin
          if (!bus.iup) mode_d = OPEN;
        end
        OPEN: begin
          if (bus.iright)   mode_d = DOORSTEP;
          else if (bus.iup) mode_d = CLOSED;
        end
        DOORSTEP: begin
          if (bus.iright) begin
            zone_d = zone_inc;
            mode_d = (zone_inc == LAST_ZONE) ? DONE : DOORSTEP;
          end else begin
            mode_d = OPEN;
          end
        end
        DONE:    mode_d = DONE;
        default: mode_d = CLOSED;
      endcase
    end
    // The move on the fault edge still lands; only later moves are frozen.
    fault_d = fault_q || bus.fault_inject || (wd_limit && (zone_d != LAST_ZONE));
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= CLOSED;
      zone_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      zone_q  <= zone_d;
      fault_q <= fault_d;
    end
  end

  // Observations decode straight from registers: no input-to-output path.
  assign zone_oh                   = zone_onehot(zone_q);
  assign bus.controllable_zone0    = zone_oh[0];
  assign bus.controllable_zone1    = zone_oh[1];
  assign bus.controllable_zone2    = zone_oh[2];
  assign bus.controllable_zone3    = zone_oh[3];
  assign bus.controllable_zone4    = zone_oh[4];
  assign bus.controllable_open     = (mode_q != CLOSED);
  assign bus.controllable_doorstep = (mode_q == DOORSTEP) || (mode_q == DONE);
  assign bus.controllable_fault    = fault_q;
  assign bus.done                  = (mode_q == DONE) && !fault_q;
  assign bus.steps                 = wd_count;

endmodule
`default_nettype wire

// File: tb/tb_passageway_agent.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_passageway_agent                                     |
// | Purpose  : Directed scoreboard bench for passageway_agent.         |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_passageway_agent;

  localparam int STEP_W = 7;

  typedef struct packed {
    logic [4:0]        zone;
    logic              open;
    logic              door;
    logic              fault;
    logic              done;
    logic [STEP_W-1:0] steps;
  } obs_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  obs_t  exp_q[$];
  string name_q[$];

  passageway_if #(.STEP_W(STEP_W)) bus ();

  passageway_agent #(
    .NZONES    (5),
    .MAX_STEPS (8),
    .STEP_W    (STEP_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(int z, bit op, bit dr, bit f, bit d, int s);
    obs_t o;
    logic [4:0] one;
    one     = 5'b00001;
    o.zone  = one << z;
    o.open  = op;
    o.door  = dr;
    o.fault = f;
    o.done  = d;
    o.steps = STEP_W'(s);
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.zone  = {bus.controllable_zone4, bus.controllable_zone3, bus.controllable_zone2,
               bus.controllable_zone1, bus.controllable_zone0};
    o.open  = bus.controllable_open;
    o.door  = bus.controllable_doorstep;
    o.fault = bus.controllable_fault;
    o.done  = bus.done;
    o.steps = bus.steps;
    return o;
  endfunction

  task automatic check(input obs_t e, input string nm);
    obs_t a;
    a = sample();
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got zone=%b open=%b door=%b fault=%b done=%b steps=%0d, want zone=%b open=%b door=%b fault=%b done=%b steps=%0d",
               nm, a.zone, a.open, a.door, a.fault, a.done, a.steps,
               e.zone, e.open, e.door, e.fault, e.done, e.steps);
    end
    tests++;
    if (!$onehot(a.zone)) begin
      fails++;
      $display("FAIL %s_onehot: got zone=%b, want exactly one bit set", nm, a.zone);
    end
  endtask

  // Monitor: every edge the DUT presents a new state; compare against the queue.
  always @(posedge clk) begin
    obs_t  e;
    string nm;
    #1;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      check(e, nm);
    end
  end

  task automatic do_reset();
    rst              = 1'b1;
    bus.iup          = 1'b0;
    bus.iright       = 1'b0;
    bus.fault_inject = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
    name_q.push_back("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step(input bit up, input bit right, input bit inj, input obs_t e, input string nm);
    bus.iup          = up;
    bus.iright       = right;
    bus.fault_inject = inj;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
  endtask

  initial begin
    tests = 0;
    fails = 0;

    // Up in CLOSED never opens; iright ignored.
    do_reset();
    step(1, 1, 0, mk(0, 0, 0, 0, 0, 1), "closed_up1");
    step(1, 0, 0, mk(0, 0, 0, 0, 0, 2), "closed_up2");
    step(1, 1, 0, mk(0, 0, 0, 0, 0, 3), "closed_up3");

    // Open, step onto doorstep, advance one zone.
    do_reset();
    step(0, 0, 0, mk(0, 1, 0, 0, 0, 1), "open");
    step(0, 1, 0, mk(0, 1, 1, 0, 0, 2), "doorstep_z0");
    step(0, 1, 0, mk(1, 1, 1, 0, 0, 3), "advance_z1");

    // Full crossing, then frozen in DONE.
    do_reset();
    step(0, 0, 0, mk(0, 1, 0, 0, 0, 1), "x_open");
    step(0, 1, 0, mk(0, 1, 1, 0, 0, 2), "x_door");
    step(1, 1, 0, mk(1, 1, 1, 0, 0, 3), "x_z1");
    step(0, 1, 0, mk(2, 1, 1, 0, 0, 4), "x_z2");
    step(1, 1, 0, mk(3, 1, 1, 0, 0, 5), "x_z3");
    step(0, 1, 0, mk(4, 1, 1, 0, 1, 6), "x_done");
    step(1, 0, 0, mk(4, 1, 1, 0, 1, 6), "done_hold1");
    step(0, 0, 0, mk(4, 1, 1, 0, 1, 6), "done_hold2");
    step(1, 1, 0, mk(4, 1, 1, 0, 1, 6), "done_hold3");

    // Step back off the doorstep at zone 2, then close.
    do_reset();
    step(0, 0, 0, mk(0, 1, 0, 0, 0, 1), "b_open");
    step(0, 1, 0, mk(0, 1, 1, 0, 0, 2), "b_door");
    step(0, 1, 0, mk(1, 1, 1, 0, 0, 3), "b_z1");
    step(0, 1, 0, mk(2, 1, 1, 0, 0, 4), "b_z2");
    step(0, 0, 0, mk(2, 1, 0, 0, 0, 5), "b_back_open");
    step(1, 0, 0, mk(2, 0, 0, 0, 0, 6), "b_close");

    // Watchdog fires when steps hits the budget of 8, then everything freezes.
    do_reset();
    for (int i = 1; i <= 7; i++) step(1, 0, 0, mk(0, 0, 0, 0, 0, i), "wd_count");
    step(1, 0, 0, mk(0, 0, 0, 1, 0, 8), "wd_fault");
    step(1, 0, 0, mk(0, 0, 0, 1, 0, 8), "wd_sticky1");
    step(0, 0, 0, mk(0, 0, 0, 1, 0, 8), "wd_sticky2");

    // Injected fault in OPEN, then asynchronous reset mid-cycle.
    do_reset();
    step(0, 0, 0, mk(0, 1, 0, 0, 0, 1), "i_open");
    step(0, 0, 0, mk(0, 1, 0, 0, 0, 2), "i_hold");
    step(0, 0, 1, mk(0, 1, 0, 1, 0, 3), "i_inject");
    step(0, 1, 0, mk(0, 1, 0, 1, 0, 3), "i_frozen");
    #2;
    rst = 1'b1;
    #1;
    check(mk(0, 0, 0, 0, 0, 0), "async_rst");

    // Fault injected on the DONE-entry edge: zone advances, done stays low.
    do_reset();
    step(0, 0, 0, mk(0, 1, 0, 0, 0, 1), "d_open");
    step(0, 1, 0, mk(0, 1, 1, 0, 0, 2), "d_door");
    step(0, 1, 0, mk(1, 1, 1, 0, 0, 3), "d_z1");
    step(0, 1, 0, mk(2, 1, 1, 0, 0, 4), "d_z2");
    step(0, 1, 0, mk(3, 1, 1, 0, 0, 5), "d_z3");
    step(0, 1, 1, mk(4, 1, 1, 1, 0, 6), "d_fault_wins");
    step(0, 0, 0, mk(4, 1, 1, 1, 0, 6), "d_frozen");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/passageway_agent.md
Name: passageway_agent

Overview:
- Reference model of the passageway system under test: an agent crossing a 5-zone corridor, one cycle per move.
- Each cycle it consumes the tester's stimulus bits iup and iright. It then updates registered zone/door/doorstep/fault flags, which the corridor monitor reads as properties of the next state.
- Used as the known-good SUT that closes the loop with the monitor in RL-tester simulations. Sticky fault is raised on step-budget exhaustion or external injection.

Parameters:
- NZONES, 5, number of corridor zones (zone indices 0..NZONES-1); terminal zone is NZONES-1.
- MAX_STEPS, 64, moves allowed before the watchdog raises fault.
- STEP_W, 7, width of the step counter; must satisfy 2^STEP_W > MAX_STEPS.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  asynchronous, active-high reset.
- iup  input  1  stimulus: 1 = up, 0 = down.
- iright  input  1  stimulus: 1 = right, 0 = left.
- fault_inject  input  1  forces sticky fault on the next edge.
- controllable_zone0..controllable_zone4  output  1 each  one-hot current zone.
- controllable_open  output  1  agent is in the door-open area or on the doorstep.
- controllable_doorstep  output  1  agent is on the doorstep; implies controllable_open.
- controllable_fault  output  1  sticky fault.
- done  output  1  zone == NZONES-1 and no fault.
- steps  output  STEP_W  moves taken since reset; saturates.

Behaviour:
- Reset (async, active-high): zone=0, mode=CLOSED, fault=0, steps=0. All outputs 0 except controllable_zone0=1.
- All outputs are registered. A stimulus sampled at edge k is reflected in the outputs after edge k; there is no combinational input-to-output path.
- Mode state machine (ileft = ~iright, idown = ~iup):
  - CLOSED: idown -> OPEN. iup -> CLOSED. iright is ignored in this mode.
  - OPEN: iright -> DOORSTEP, same zone. ileft&iup -> CLOSED. ileft&idown -> OPEN, hold.
  - DOORSTEP with zone < NZONES-1: iright -> zone+1 and mode=DOORSTEP. ileft -> OPEN, same zone. iup/idown are ignored.
  - DONE (entered when zone reaches NZONES-1): mode, zone and steps frozen. Outputs show zone4=1, open=1, doorstep=1.
- Output encoding:
  - CLOSED: open=0, doorstep=0.
  - OPEN: open=1, doorstep=0.
  - DOORSTEP: open=1, doorstep=1.
- Invariants the monitor relies on; verification asserts these every cycle:
  - Never open while iup was sampled in CLOSED.
  - Never doorstep-without-zone-change after ileft in OPEN.
  - From DOORSTEP, the zone advances iff iright.
  - Zone changes only by +1, and only from DOORSTEP.
- Step counter:
  - Increments on every edge outside DONE while fault=0.
  - Saturates at 2^STEP_W-1.
  - When steps reaches MAX_STEPS with zone < NZONES-1, fault is set on that edge.
- Fault:
  - Set by fault_inject or the watchdog; cleared only by rst.
  - While fault=1, mode, zone and steps are frozen and done=0.
  - If fault_inject coincides with the DONE-entry edge, fault wins: zone advances, fault=1, done=0.
- Exactly one controllable_zone* is high at all times, including during reset.
- rst asserted mid-move: all state returns to reset values immediately, regardless of pending inputs.

Decomposition:
- Package passageway_pkg:
  - mode_t enum {CLOSED, OPEN, DOORSTEP, DONE}.
  - Constant NZONES_DEFAULT=5.
  - Function zone_onehot(idx) returning a 5-bit vector.
- Sub-module passageway_step_watchdog (saturating counter plus limit compare), reusable by the tester harness.
- Mode FSM and zone register live in passageway_agent.

Test Plan:
- Reset then iup=1 for 3 cycles -> controllable_open=0, zone0=1, steps=3.
- Sequence (iup,iright) = (0,0),(0,1),(0,1) -> after edge 1 open=1/doorstep=0; edge 2 doorstep=1 zone0; edge 3 zone1=1, doorstep=1.
- Full crossing: (0,0),(0,1), then four times (x,1) -> zone4=1, done=1, steps=6. Further stimulus leaves all outputs unchanged.
- In DOORSTEP zone2 apply iright=0 -> zone2 held, doorstep=0, open=1. Then (1,0) -> open=0.
- MAX_STEPS=8, stimulus constantly (1,0) -> fault=1 after edge 8, steps=8, done=0; stays 1 until rst.
- fault_inject pulse at step 3 while in OPEN, then rst asserted asynchronously mid-cycle -> fault=1 after edge 3. On rst: outputs go immediately to zone0=1, open=0, fault=0, steps=0.
